// File: rtl/booth_arbiter.sv
// Round-robin front end that shares one sequential Booth multiplier among NUM_REQ requesters.
// One transaction at a time: grant, issue, wait for the multiplier, hold the tagged response.
module booth_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned OPERAND_BITS = 4,
  parameter int unsigned ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*OPERAND_BITS-1:0] req_a,
  input  logic [NUM_REQ*OPERAND_BITS-1:0] req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [ID_BITS-1:0]           rsp_id,
  output logic [2*OPERAND_BITS-1:0]    rsp_product,
  input  logic                         rsp_ready,
  output logic                         mul_start,
  output logic [OPERAND_BITS-1:0]      mul_a,
  output logic [OPERAND_BITS-1:0]      mul_b,
  input  logic                         mul_done,
  input  logic [2*OPERAND_BITS-1:0]    mul_product,
  output logic                         busy
);

  localparam int unsigned ProdBits = 2 * OPERAND_BITS;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ID_BITS-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0]      rsp_id_q, rsp_id_d;
  logic [OPERAND_BITS-1:0] op_a_q, op_a_d;
  logic [OPERAND_BITS-1:0] op_b_q, op_b_d;
  logic [ProdBits-1:0]     prod_q, prod_d;

  logic                    grant_vld;
  logic [ID_BITS-1:0]      grant_id;
  logic [ID_BITS-1:0]      cand_id;
  logic [OPERAND_BITS-1:0] sel_a, sel_b;

  // Rotating priority search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand_id   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_id = ID_BITS'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_vld && req_valid[cand_id]) begin
        grant_vld = 1'b1;
        grant_id  = cand_id;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant_id == ID_BITS'(j)) begin
        sel_a = req_a[j*OPERAND_BITS +: OPERAND_BITS];
        sel_b = req_b[j*OPERAND_BITS +: OPERAND_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      rsp_id_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rsp_id_q <= rsp_id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      prod_q   <= prod_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    rsp_id_d = rsp_id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    prod_d   = prod_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          rsp_id_d = grant_id;
          state_d  = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mul_done) begin
          prod_d  = mul_product;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rr_ptr_d = ID_BITS'((32'(rsp_id_q) + 32'd1) % NUM_REQ);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_vld) begin
      req_ready[grant_id] = 1'b1;
    end
    rsp_valid = (state_q == StResp);
    mul_start = (state_q == StIssue);
    busy      = (state_q != StIdle);
  end

  assign rsp_id      = rsp_id_q;
  assign rsp_product = prod_q;
  assign mul_a       = op_a_q;
  assign mul_b       = op_b_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed bench for booth_arbiter; the bench plays both the requesters and the multiplier.
module tb_booth_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_product;
  logic        rsp_ready;
  logic        mul_start;
  logic [3:0]  mul_a, mul_b;
  logic        mul_done;
  logic [7:0]  mul_product;
  logic        busy;

  int tests = 0;
  int fails = 0;

  booth_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_product(rsp_product),
    .rsp_ready  (rsp_ready),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_product(mul_product),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
    req_a[id*4 +: 4] = a;
    req_b[id*4 +: 4] = b;
  endtask

  // Raise one request, wait for its grant, transfer; returns in the ISSUE cycle.
  task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    set_ops(id, a, b);
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!req_ready[id]) begin
      fails++;
      $display("FAIL issue_grant_req%0d: req_ready=%b, required bit %0d set", id, req_ready, id);
    end
    tick();
    req_valid[id] = 1'b0;
  endtask

  // Multiplier model: done k cycles after the start cycle; returns in the first RESP cycle.
  task automatic serve(input int k);
    int n;
    logic [7:0] sa, sb;
    n = 0;
    while (!mul_start && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!mul_start) begin
      fails++;
      $display("FAIL serve_start: mul_start=%b, required 1", mul_start);
    end
    repeat (k) tick();
    sa = {{4{mul_a[3]}}, mul_a};
    sb = {{4{mul_b[3]}}, mul_b};
    mul_product = sa * sb;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    tests++;
    if ({req_ready, rsp_valid, mul_start, busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b rsp_valid=%b start=%b busy=%b, required all 0",
               req_ready, rsp_valid, mul_start, busy);
    end
    tests++;
    if ({rsp_id, rsp_product, mul_a, mul_b} !== 18'b0) begin
      fails++;
      $display("FAIL reset_data: id=%0d prod=%h a=%h b=%h, required all 0",
               rsp_id, rsp_product, mul_a, mul_b);
    end
  endtask

  task automatic test_single();
    set_ops(2, 4'd3, 4'd5);
    req_valid = 4'b0100;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL single_ready: got %b, required 0100", req_ready);
    end
    tick();
    tests++;
    if ({req_ready, mul_start, busy, mul_a, mul_b} !== {4'b0000, 1'b1, 1'b1, 4'd3, 4'd5}) begin
      fails++;
      $display("FAIL single_issue: ready=%b start=%b busy=%b a=%h b=%h, required 0000 1 1 3 5",
               req_ready, mul_start, busy, mul_a, mul_b);
    end
    req_valid = 4'b0000;
    repeat (4) tick();
    tests++;
    if ({mul_start, rsp_valid, busy} !== 3'b001) begin
      fails++;
      $display("FAIL single_wait: start=%b rsp_valid=%b busy=%b, required 0 0 1",
               mul_start, rsp_valid, busy);
    end
    mul_product = 8'h0F;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    tests++;
    if ({rsp_valid, rsp_id, rsp_product} !== {1'b1, 2'd2, 8'h0F}) begin
      fails++;
      $display("FAIL single_rsp: valid=%b id=%0d prod=%h, required 1 2 0f",
               rsp_valid, rsp_id, rsp_product);
    end
    consume();
    tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL single_done: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] a_tab [4];
    logic [3:0] b_tab [4];
    logic [7:0] p_tab [4];
    logic [3:0] exp_oh;
    int n;
    a_tab = '{4'd1, 4'd2, 4'hD, 4'd7};
    b_tab = '{4'd6, 4'hF, 4'd2, 4'd7};
    p_tab = '{8'h06, 8'hFE, 8'hFA, 8'h31};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, a_tab[i], b_tab[i]);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      #1;
      while (req_ready == 4'b0 && n < 20) begin
        tick();
        n++;
      end
      exp_oh = 4'b0001 << (t % 4);
      tests++;
      if (!$onehot0(req_ready) || req_ready !== exp_oh) begin
        fails++;
        $display("FAIL rr_grant[%0d]: req_ready=%b, required %b", t, req_ready, exp_oh);
      end
      tick();
      serve(1);
      tests++;
      if ({rsp_valid, rsp_id, rsp_product} !== {1'b1, 2'(t % 4), p_tab[t % 4]}) begin
        fails++;
        $display("FAIL rr_rsp[%0d]: valid=%b id=%0d prod=%h, required 1 %0d %h",
                 t, rsp_valid, rsp_id, rsp_product, t % 4, p_tab[t % 4]);
      end
      tick();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_signed();
    issue(1, 4'hD, 4'd5);
    serve(2);
    tests++;
    if ({rsp_valid, rsp_id, rsp_product} !== {1'b1, 2'd1, 8'hF1}) begin
      fails++;
      $display("FAIL signed_m3x5: valid=%b id=%0d prod=%h, required 1 1 f1",
               rsp_valid, rsp_id, rsp_product);
    end
    consume();
    issue(2, 4'h8, 4'h8);
    serve(3);
    tests++;
    if ({rsp_valid, rsp_id, rsp_product} !== {1'b1, 2'd2, 8'h40}) begin
      fails++;
      $display("FAIL signed_m8xm8: valid=%b id=%0d prod=%h, required 1 2 40",
               rsp_valid, rsp_id, rsp_product);
    end
    consume();
  endtask

  task automatic test_backpressure();
    issue(0, 4'd2, 4'd3);
    serve(1);
    set_ops(1, 4'd1, 4'd1);
    set_ops(2, 4'd1, 4'd1);
    set_ops(3, 4'd1, 4'd1);
    req_valid = 4'b1110;
    #1;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({rsp_valid, rsp_id, rsp_product, req_ready} !== {1'b1, 2'd0, 8'h06, 4'b0000}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b id=%0d prod=%h ready=%b, required 1 0 06 0000",
                 i, rsp_valid, rsp_id, rsp_product, req_ready);
      end
      if (i == 3) begin
        mul_product = 8'hAA;
        mul_done = 1'b1;
      end
      tick();
      mul_done = 1'b0;
    end
    consume();
    tests++;
    if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
      fails++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b, required 0 0010",
               rsp_valid, req_ready);
    end
    req_valid = 4'b0000;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_withdraw: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    issue(3, 4'd1, 4'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_a, mul_b, busy} !== 25'b0) begin
      fails++;
      $display("FAIL rstw_outputs: ready=%b valid=%b id=%0d prod=%h start=%b a=%h b=%h busy=%b",
               req_ready, rsp_valid, rsp_id, rsp_product, mul_start, mul_a, mul_b, busy);
    end
    mul_product = 8'h55;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL rstw_stale_done: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    set_ops(0, 4'd1, 4'd1);
    req_valid = 4'b1001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL rstw_ptr: req_ready=%b, required 0001", req_ready);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_withdrawal();
    issue(0, 4'd2, 4'd2);
    set_ops(1, 4'd5, 4'd5);
    req_valid = 4'b0010;
    serve(2);
    tests++;
    if ({req_ready, rsp_id, rsp_product} !== {4'b0000, 2'd0, 8'h04}) begin
      fails++;
      $display("FAIL wd_busy: ready=%b id=%0d prod=%h, required 0000 0 04",
               req_ready, rsp_id, rsp_product);
    end
    set_ops(2, 4'hE, 4'd3);
    req_valid = 4'b0100;
    consume();
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL wd_grant: req_ready=%b, required 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    serve(1);
    tests++;
    if ({rsp_valid, rsp_id, rsp_product} !== {1'b1, 2'd2, 8'hFA}) begin
      fails++;
      $display("FAIL wd_rsp: valid=%b id=%0d prod=%h, required 1 2 fa",
               rsp_valid, rsp_id, rsp_product);
    end
    consume();
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 1'b0;
    mul_done    = 1'b0;
    mul_product = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_signed();
    test_backpressure();
    test_reset_mid_wait();
    test_withdrawal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
